apb_rr_master: RTL and testbench

//   Round-robin APB master that shares one APB slave (apb_ram, 32x32-bit) among NREQ local requesters.

---
 rtl/apb_rr_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 53 +++++
 rtl/apb_rr_master.sv | 202 ++++++++++++++++++++
 tb/tb_apb_rr_master.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_rr_pkg.sv
// ---------------------------------------------------------------------------
// apb_rr_pkg
//   Shared types and constants for the round-robin APB master.
//   - apb_mst_state_t : APB master FSM state encoding
//   - RSP_OK / RSP_ERR : values driven on rsp_err with a completion pulse
// ---------------------------------------------------------------------------
package apb_rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_mst_state_t;

  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter with a rotating priority pointer.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset (pointer -> 0)
//     req       : request vector, one bit per requester
//     advance   : when high and a winner exists, pointer moves to winner+1
//     grant     : one-hot winner (combinational)
//     valid     : at least one request present (combinational)
//   The lowest index at or after the pointer wins.
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic            valid
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  int            idx;

  // Scan from the pointer, wrapping, and take the first active request.
  always_comb begin
    grant = '0;
    win   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr) + off) % NREQ;
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        win        = PW'(idx);
        valid      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && valid) begin
      ptr <= (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// ---------------------------------------------------------------------------
// apb_rr_master
//   Round-robin APB master sharing one APB slave among NREQ requesters.
//   A winner is picked in IDLE; its fields are latched into the APB output
//   registers, then SETUP (psel) and ACCESS (psel+penable) follow until
//   pready. The completion is returned as a one-cycle rsp_valid pulse.
//   Every transaction ends in at least one IDLE cycle.
//
//   Ports:
//     pclk, preset           : clock, asynchronous active-high reset
//     req_valid/write        : per-requester command valid and direction
//     req_addr/req_wdata     : packed per-requester address / write data
//     req_ready              : one-hot one-cycle accept pulse (registered,
//                              rises together with psel in SETUP)
//     rsp_valid/rdata/err    : one-hot completion pulse with read data/error
//     psel/penable/pwrite/
//     paddr/pwdata           : APB request outputs (registered)
//     prdata/pready/pslverr  : APB slave response
//
//   Optional feature macro: APB_TIMEOUT_EN
//     Aborts an ACCESS phase after TIMEOUT cycles without pready and
//     returns rsp_err=1 with rsp_rdata=0.
// ---------------------------------------------------------------------------
module apb_rr_master
  import apb_rr_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  req_ready,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_err,
  output logic             psel,
  output logic             penable,
  output logic             pwrite,
  output logic [AW-1:0]    paddr,
  output logic [DW-1:0]    pwdata,
  input  logic [DW-1:0]    prdata,
  input  logic             pready,
  input  logic             pslverr
);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("apb_rr_master: NREQ must be 2..8 and TIMEOUT >= 1");
  end

  apb_mst_state_t state, next_state;

  logic [NREQ-1:0] arb_grant;
  logic            arb_valid;
  logic            arb_advance;

  // Owner of the transaction in flight; paddr/pwrite/pwdata hold the rest.
  logic [NREQ-1:0] owner, owner_d;

  logic            sel_write;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  logic            psel_d, penable_d, pwrite_d;
  logic [AW-1:0]   paddr_d;
  logic [DW-1:0]   pwdata_d;
  logic [NREQ-1:0] req_ready_d, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_d;
  logic            rsp_err_d;
  logic            tmo_hit;

  assign arb_advance = (state == ST_IDLE);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (pclk),
    .rst     (preset),
    .req     (req_valid),
    .advance (arb_advance),
    .grant   (arb_grant),
    .valid   (arb_valid)
  );

  // Field mux driven by the one-hot grant.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts completed ACCESS cycles; cleared whenever not in ACCESS.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tmo_cnt <= '0;
    end else if (state == ST_ACCESS) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = (state == ST_ACCESS) && !pready && (tmo_cnt == TW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (arb_valid) next_state = ST_SETUP;
      ST_SETUP:  next_state = ST_ACCESS;
      ST_ACCESS: if (pready || tmo_hit) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    psel_d      = (next_state != ST_IDLE);
    penable_d   = (next_state == ST_ACCESS);
    pwrite_d    = pwrite;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    owner_d     = owner;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = RSP_OK;

    if (state == ST_IDLE && arb_valid) begin
      pwrite_d    = sel_write;
      paddr_d     = sel_addr;
      pwdata_d    = sel_wdata;
      owner_d     = arb_grant;
      req_ready_d = arb_grant;
    end

    if (state == ST_ACCESS) begin
      if (pready) begin
        rsp_valid_d = owner;
        rsp_err_d   = pslverr ? RSP_ERR : RSP_OK;
        rsp_rdata_d = pwrite ? '0 : prdata;
      end else if (tmo_hit) begin
        rsp_valid_d = owner;
        rsp_err_d   = RSP_ERR;
      end
    end
  end

  // Output and command registers
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      owner     <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      owner     <= owner_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// ---------------------------------------------------------------------------
// tb_apb_rr_master
//   Directed bench for apb_rr_master with a 32x32 APB RAM model.
//   Handshake: a requester raises req_valid with its fields and holds them
//   until it sees req_ready; completion is a one-cycle rsp_valid pulse.
//   Define APB_TIMEOUT_EN for the abort scenario.
// ---------------------------------------------------------------------------
module tb_apb_rr_master;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic preset;
  always #5 pclk = ~pclk;

  logic [NREQ-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0]      rsp_rdata, pwdata, prdata;
  logic [AW-1:0]      paddr;
  logic               rsp_err, psel, penable, pwrite, pready, pslverr;

  apb_rr_master #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
    .pclk      (pclk),
    .preset    (preset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  // ---------------- APB RAM model ----------------
  logic [31:0] mem [0:31];
  int          acc_cnt = 0;
  int          wait_states = 0;
  logic        stall = 1'b0;

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (psel && penable && pready && pwrite && paddr < 32)
      mem[paddr[4:0]] <= pwdata;
  end

  always_comb begin
    pready  = psel && penable && !stall && (acc_cnt >= wait_states);
    pslverr = pready && (paddr >= 32);
    prdata  = (pready && !pwrite && paddr < 32) ? mem[paddr[4:0]] : 32'h0;
  end

  // ---------------- scoreboard / checking ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_fields(input int r, input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_write[r]          = wr;
    req_addr[r*AW +: AW]  = a;
    req_wdata[r*DW +: DW] = d;
  endtask

  // Raise a request, wait (bounded) for its accept pulse, then drop valid.
  task automatic issue(input int r, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic got;
    set_fields(r, wr, a, d);
    req_valid[r] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      if (req_ready[r]) got = 1'b1;
    end
    req_valid[r] = 1'b0;
    check($sformatf("grant_seen_%0d", r), 32'(got), 32'd1);
  endtask

  task automatic wait_rsp(input int r, output logic [31:0] rdata, output logic err, output int cycles);
    logic got;
    got    = 1'b0;
    cycles = 0;
    rdata  = '0;
    err    = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      cycles++;
      if (rsp_valid != '0) begin
        got   = 1'b1;
        rdata = rsp_rdata;
        err   = rsp_err;
        check("rsp_owner", 32'(rsp_valid), 32'd1 << r);
      end
    end
    check("rsp_seen", 32'(got), 32'd1);
  endtask

  logic [31:0] rd, last_grant, e;
  logic        er, seen, got;
  int          cyc, n_rsp, cnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    // -------- reset, with both requesters already valid --------
    preset    = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    set_fields(0, 1'b1, 32'd2, 32'h1234_5678);
    set_fields(1, 1'b0, 32'd2, 32'h0);
    req_valid = 2'b11;
    wait_states = 1;
    repeat (3) tick();
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    preset = 1'b0;

    // -------- both requesters valid every cycle: 0,1,0,1,... --------
    for (int k = 0; k < 6; k++) exp_q.push_back(32'(k % 2));
    last_grant = '0;
    n_rsp = 0;
    for (int c = 0; c < 300 && n_rsp < 6; c++) begin
      tick();
      if (req_ready != '0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("t2_grant", 32'(req_ready), 32'd1 << e);
        last_grant = 32'(req_ready);
      end
      if (rsp_valid != '0) begin
        check("t2_rsp_owner", 32'(rsp_valid), last_grant);
        check("t2_rsp_onehot", 32'($onehot(rsp_valid)), 32'd1);
        if (rsp_valid[1]) check("t2_rdata", rsp_rdata, 32'h1234_5678);
        n_rsp++;
      end
    end
    req_valid = '0;
    check("t2_rsp_count", 32'(n_rsp), 32'd6);

    // -------- write then read, req0, addr 5 --------
    wait_states = 0;
    tick();
    issue(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    check("t1_setup_psel", 32'(psel), 32'd1);
    check("t1_setup_penable", 32'(penable), 32'd0);
    check("t1_paddr", paddr, 32'd5);
    check("t1_pwrite", 32'(pwrite), 32'd1);
    check("t1_pwdata", pwdata, 32'hDEAD_BEEF);
    tick();
    check("t1_access_psel", 32'(psel), 32'd1);
    check("t1_access_penable", 32'(penable), 32'd1);
    wait_rsp(0, rd, er, cyc);
    check("t1_wr_err", 32'(er), 32'd0);
    check("t1_wr_rdata", rd, 32'd0);
    check("t1_wr_latency", 32'(cyc), 32'd1);
    wait_states = 2;
    issue(0, 1'b0, 32'd5, 32'h0);
    wait_rsp(0, rd, er, cyc);
    check("t1_rd_rdata", rd, 32'hDEAD_BEEF);
    check("t1_rd_err", 32'(er), 32'd0);
    check("t1_rd_latency", 32'(cyc), 32'd4);

    // -------- last valid address, then out-of-range read on req1 --------
    wait_states = 0;
    issue(1, 1'b1, 32'd31, 32'hA5A5_0031);
    wait_rsp(1, rd, er, cyc);
    check("t3_wr31_err", 32'(er), 32'd0);
    issue(1, 1'b0, 32'd31, 32'h0);
    wait_rsp(1, rd, er, cyc);
    check("t3_rd31_rdata", rd, 32'hA5A5_0031);
    issue(1, 1'b0, 32'd40, 32'h0);
    wait_rsp(1, rd, er, cyc);
    check("t3_oor_err", 32'(er), 32'd1);

    // -------- fields changed after grant are ignored --------
    wait_states = 3;
    set_fields(0, 1'b1, 32'd3, 32'h0000_0066);
    req_valid[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      if (req_ready[0]) got = 1'b1;
    end
    check("t6_grant_seen", 32'(got), 32'd1);
    set_fields(0, 1'b1, 32'd9, 32'h0000_0077);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (psel) begin
        check("t6_paddr", paddr, 32'd3);
        check("t6_pwdata", pwdata, 32'h0000_0066);
      end
      if (rsp_valid[0]) got = 1'b1;
      else tick();
    end
    req_valid[0] = 1'b0;
    check("t6_rsp_seen", 32'(got), 32'd1);
    issue(0, 1'b0, 32'd3, 32'h0);
    wait_rsp(0, rd, er, cyc);
    check("t6_readback", rd, 32'h0000_0066);

    // -------- reset pulse during ACCESS of a req0 write --------
    wait_states = 0;
    stall = 1'b1;
    issue(0, 1'b1, 32'd7, 32'h0000_4444);
    tick();
    tick();
    check("t4_in_access", 32'(penable), 32'd1);
    preset = 1'b1;
    #1;
    check("t4_psel", 32'(psel), 32'd0);
    check("t4_penable", 32'(penable), 32'd0);
    check("t4_req_ready", 32'(req_ready), 32'd0);
    check("t4_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    tick();
    preset = 1'b0;
    stall = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid != '0) seen = 1'b1;
    end
    check("t4_no_rsp", 32'(seen), 32'd0);
    set_fields(0, 1'b0, 32'd5, 32'h0);
    set_fields(1, 1'b0, 32'd31, 32'h0);
    req_valid = 2'b11;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (req_ready != '0) begin
        got = 1'b1;
        check("t4_first_grant", 32'(req_ready), 32'd1);
      end
    end
    req_valid = '0;
    check("t4_grant_seen", 32'(got), 32'd1);
    wait_rsp(0, rd, er, cyc);
    check("t4_rdata", rd, 32'hDEAD_BEEF);

    // -------- slave never ready --------
    stall = 1'b1;
    issue(0, 1'b0, 32'd5, 32'h0);
    tick();
    check("t5_penable_rose", 32'(penable), 32'd1);
`ifdef APB_TIMEOUT_EN
    cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      cnt++;
      if (rsp_valid != '0) begin
        got = 1'b1;
        check("t5_owner", 32'(rsp_valid), 32'd1);
        check("t5_err", 32'(rsp_err), 32'd1);
        check("t5_rdata", rsp_rdata, 32'd0);
        check("t5_psel_low", 32'(psel), 32'd0);
      end
    end
    check("t5_timeout_cycles", 32'(cnt), 32'd16);
    stall = 1'b0;
`else
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rsp_valid != '0) seen = 1'b1;
    end
    check("t5_no_rsp_while_stalled", 32'(seen), 32'd0);
    check("t5_still_psel", 32'(psel), 32'd1);
    check("t5_still_penable", 32'(penable), 32'd1);
    check("t5_paddr_held", paddr, 32'd5);
    stall = 1'b0;
    wait_rsp(0, rd, er, cyc);
    check("t5_late_rdata", rd, 32'hDEAD_BEEF);
    check("t5_late_err", 32'(er), 32'd0);
`endif

    tick();
    tick();
    // -------- final report --------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
